fifo_mst_xfer: RTL
==================

# fifo_mst_xfer

FT600 FIFO-master transfer sequencer, directly downstream of the FIFO-master arbiter. It consumes the arbiter's one-cycle `grant` together with `t_ep_num` and `m_rd_wr`. It then runs one bounded burst on the FT600 bus: a command phase followed by data beats to or from the local endpoint buffers. It reports `idle_st` back to the arbiter, which gates new grants.

## Interface
Parameters:
- `DW`, 32: FT600 data bus width; byte enables are `DW/8` bits.
- `BURST_MAX`, 1024: maximum data beats per grant.

Ports (all synchronous to `fifoClk`):
- `fifoClk`  in  1  FIFO interface clock; the only clock.
- `fifoRstn`  in  1  reset, synchronous, active-low.
- `grant`  in  1  one-cycle start pulse from the arbiter.
- `t_ep_num`  in  `CNT_CODE_NUM_CHNLS+1`  granted endpoint, 1..4.
- `m_rd_wr`  in  1  direction: 1 = OUT EP (master reads the bus), 0 = IN EP (master writes the bus).
- `idle_st`  out  1  high only in IDLE.
- `rxf_n`  in  1  FT600 has read data; active-low.
- `txe_n`  in  1  FT600 can accept write data; active-low.
- `bus_din`  in  `DW`  FT600 data bus, input half.
- `bus_dout`  out  `DW`  FT600 data bus, output half.
- `bus_be`  out  `DW/8`  byte enables, driven on write beats.
- `bus_drv`  out  1  output-enable for the `bus_dout` pad tristate.
- `wr_n`  out  1  FT600 write strobe; active-low.
- `rd_n`  out  1  FT600 read strobe; active-low.
- `oe_n`  out  1  FT600 output enable; active-low.
- `mem_wr_en`  out  1  write strobe to the OUT buffer.
- `mem_wdata`  out  `DW`  write data to the OUT buffer.
- `mem_full`  in  1  OUT buffer full.
- `mem_rd_en`  out  1  pop strobe to the IN buffer (first-word fall-through).
- `mem_rdata`  in  `DW`  IN buffer head word.
- `mem_empty`  in  1  IN buffer empty.
- `mem_ep`  out  `CNT_CODE_NUM_CHNLS+1`  latched endpoint, selects the buffer.
- `xfer_done`  out  1  one-cycle pulse in END.
- `xfer_len`  out  `$clog2(BURST_MAX+1)`  beat count; valid while `xfer_done` is high.
- `grant_err`  out  1  sticky flag: `grant` arrived outside IDLE.

## Operation
- **Reset values:** all registered outputs are held at these values while `fifoRstn` is low. Strobes `wr_n`, `rd_n`, `oe_n` = 1. All other outputs = 0, except `idle_st` = 1. State = IDLE, beat counter = 0.
- **IDLE:** when `grant` is high, latch `t_ep_num` into `mem_ep` and latch `m_rd_wr`, then go to CMD.
- **CMD (1 cycle):**
  - Drive `bus_drv`=1, `wr_n`=0.
  - `bus_dout[7:0]` = {dir, 4'b0, ep[2:0]}; all other `bus_dout` bits = 0.
  - Next state: TURN if dir = 1, otherwise WR.
- **TURN (1 cycle):** `bus_drv`=0, `oe_n`=0, then go to RD.
- **RD:**
  - Hold `oe_n`=0; `rd_n`=0 while cnt < `BURST_MAX` and `mem_full`=0.
  - A beat occurs in a cycle where `rd_n`=0 and `rxf_n`=0. On the next cycle, `mem_wr_en`=1 and `mem_wdata` = the sampled `bus_din`.
  - Exit to END when `rxf_n`=1, `mem_full`=1, or cnt = `BURST_MAX`.
- **WR:**
  - beat = `txe_n`=0 & `mem_empty`=0 & cnt < `BURST_MAX`.
  - `mem_rd_en` = beat, combinational.
  - Registered on the same edge: `bus_dout` ← `mem_rdata`, `bus_be` ← all ones, `wr_n` ← ~beat, `bus_drv` ← 1.
  - Exit to END when `txe_n`=1, `mem_empty`=1, or cnt = `BURST_MAX`.
- **END (1 cycle):**
  - All strobes high, `bus_drv`=0.
  - `xfer_done`=1, `xfer_len` = cnt.
  - Clear cnt, then go to IDLE.
- **Beat counter:** saturating, width `$clog2(BURST_MAX+1)`, increments once per beat; wrap-around is impossible.
- **Grant outside IDLE:** ignored, and sets `grant_err` (cleared only by reset).
- **Zero-beat burst** (exit condition already true on the first RD/WR cycle): END reports `xfer_len`=0.
- **Simultaneous exit conditions:** a single exit to END; the beat in that cycle counts only if its beat condition held.

## Timing
- **grant to command:** `grant` sampled at edge N; CMD is active in cycle N+1; `idle_st` falls at N+1.
- **Read path:** first `rd_n` low at N+3; read data reaches `mem_wr_en` one cycle after the bus beat.
- **Write path:** first `wr_n` low at N+3, with `bus_dout` registered from the popped word.
- **Bus turnaround:** at least one cycle with `bus_drv`=0 between CMD and RD; `bus_drv` is low in END.
- **Return to idle:** `idle_st` rises the cycle after END, so the arbiter sees at least 1 idle cycle between bursts.
- **Reset mid-burst:** on the first edge with `fifoRstn`=0, state returns to IDLE, strobes go high, `bus_drv` goes low, and no `xfer_done` is issued.

## Structure
- **Shared package `pkg_ft601_ctrl_defines`:**
  - `CNT_CODE_NUM_CHNLS` (already exists).
  - New state enum `xfer_st_t` {IDLE, CMD, TURN, RD, WR, END}.
  - Command-byte field constants.
- **Sub-modules:** none needed; a single FSM plus counter.

## Test plan
- `grant` with ep=2, dir=1; `rxf_n` low for 5 beats, then high → CMD byte 8'h82, 5 `mem_wr_en` pulses carrying the bus data in order, `xfer_len`=5, `idle_st` high at END+1.
- `grant` with ep=3, dir=0; IN buffer holds 3 words A, B, C; `txe_n`=0 → CMD byte 8'h03, `wr_n` low for 3 cycles with `bus_dout` = A, B, C, 3 `mem_rd_en` pulses, `xfer_len`=3.
- `BURST_MAX`=4; `rxf_n` held low → exactly 4 beats, `xfer_len`=4, `rd_n` high before a 5th beat.
- `mem_full` rises after beat 2 of a read → `rd_n` high, END, `xfer_len`=2. Zero-beat case (`txe_n`=1 at WR entry) → `xfer_len`=0.
- `grant` pulsed during RD → burst unaffected, `grant_err`=1 until reset.
- `fifoRstn` low mid-WR → all outputs at reset values on the next edge, no `xfer_done`. A new `grant` after release → normal burst.

Source files
------------

// File: rtl/pkg_ft601_ctrl_defines.sv
// Shared definitions for the FT600 FIFO-master control path.
package pkg_ft601_ctrl_defines;

    // Endpoint code width is CNT_CODE_NUM_CHNLS+1 bits; endpoints 1..4.
    localparam int CNT_CODE_NUM_CHNLS = 2;

    // Transfer sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        CMD,
        TURN,
        RD,
        WR,
        END
    } xfer_st_t;

    // Command byte layout: {dir, 4'b0, ep[2:0]}.
    localparam int CMD_DIR_BIT = 7;
    localparam int CMD_EP_MSB  = 2;
    localparam int CMD_EP_W    = CMD_EP_MSB + 1;

    // Build the command byte placed on bus_dout[7:0] in CMD.
    function automatic logic [7:0] cmd_byte(input logic dir, input logic [CMD_EP_W-1:0] ep);
        logic [7:0] b;
        b = '0;
        b[CMD_DIR_BIT] = dir;
        b[CMD_EP_MSB:0] = ep;
        return b;
    endfunction

endpackage

// File: rtl/fifo_mst_xfer.sv
// FT600 FIFO-master transfer sequencer: one command phase plus a bounded
// burst of read or write beats per arbiter grant.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for grant; idle_st high
//   CMD   | command byte on the bus, wr_n low, bus driven
//   TURN  | bus released, oe_n low, FT600 takes the bus
//   RD    | read beats from FT600 into the OUT buffer
//   WR    | write beats from the IN buffer onto the FT600 bus
//   END   | strobes high, xfer_done/xfer_len reported, counter cleared
module fifo_mst_xfer
    import pkg_ft601_ctrl_defines::*;
#(
    parameter int DW        = 32,
    parameter int BURST_MAX = 1024,
    localparam int EPW      = CNT_CODE_NUM_CHNLS + 1,
    localparam int CW       = $clog2(BURST_MAX + 1)
) (
    input  logic            fifoClk,
    input  logic            fifoRstn,
    input  logic            grant,
    input  logic [EPW-1:0]  t_ep_num,
    input  logic            m_rd_wr,
    output logic            idle_st,
    input  logic            rxf_n,
    input  logic            txe_n,
    input  logic [DW-1:0]   bus_din,
    output logic [DW-1:0]   bus_dout,
    output logic [DW/8-1:0] bus_be,
    output logic            bus_drv,
    output logic            wr_n,
    output logic            rd_n,
    output logic            oe_n,
    output logic            mem_wr_en,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_full,
    output logic            mem_rd_en,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_empty,
    output logic [EPW-1:0]  mem_ep,
    output logic            xfer_done,
    output logic [CW-1:0]   xfer_len,
    output logic            grant_err
);

    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

    xfer_st_t          state_q;
    xfer_st_t          state_d;
    logic [CW-1:0]     cnt_q;
    logic              dir_q;
    logic              at_max;
    logic              rd_beat;
    logic              wr_beat;
    logic              start;

    logic              wr_n_q;
    logic [DW-1:0]     bus_dout_q;
    logic [DW/8-1:0]   bus_be_q;
    logic              mem_wr_en_q;
    logic [DW-1:0]     mem_wdata_q;
    logic [EPW-1:0]    mem_ep_q;
    logic              grant_err_q;

    assign at_max = (cnt_q == CNT_MAX);
    assign start  = (state_q == IDLE) && grant;

    // Beat qualifiers; rd_n is derived from the same terms, so in RD a cycle
    // is either a beat or an exit, never both.
    always_comb begin
        rd_beat = 1'b0;
        wr_beat = 1'b0;
        if (state_q == RD) begin
            rd_beat = !at_max && !mem_full && !rxf_n;
        end
        if (state_q == WR) begin
            wr_beat = !at_max && !mem_empty && !txe_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = CMD;
            CMD:     state_d = dir_q ? TURN : WR;
            TURN:    state_d = RD;
            RD:      if (!rd_beat) state_d = END;
            WR:      if (!wr_beat) state_d = END;
            END:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge fifoClk) begin
        if (!fifoRstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturating beat counter, cleared as END is left.
    always_ff @(posedge fifoClk) begin
        if (!fifoRstn) begin
            cnt_q <= '0;
        end else if (state_q == END) begin
            cnt_q <= '0;
        end else if ((rd_beat || wr_beat) && !at_max) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Latch direction and endpoint at grant; flag grants that arrive mid-burst.
    always_ff @(posedge fifoClk) begin
        if (!fifoRstn) begin
            dir_q       <= 1'b0;
            mem_ep_q    <= '0;
            grant_err_q <= 1'b0;
        end else begin
            if (start) begin
                dir_q    <= m_rd_wr;
                mem_ep_q <= t_ep_num;
            end
            if (grant && (state_q != IDLE)) begin
                grant_err_q <= 1'b1;
            end
        end
    end

    // Write side of the bus: command byte on grant, popped word on each write
    // beat. wr_n lands one cycle after the decision, aligned with its data.
    always_ff @(posedge fifoClk) begin
        if (!fifoRstn) begin
            wr_n_q     <= 1'b1;
            bus_dout_q <= '0;
            bus_be_q   <= '0;
        end else begin
            wr_n_q   <= 1'b1;
            bus_be_q <= '0;
            if (start) begin
                wr_n_q     <= 1'b0;
                bus_dout_q <= DW'(cmd_byte(m_rd_wr, t_ep_num));
            end else if (wr_beat) begin
                wr_n_q     <= 1'b0;
                bus_dout_q <= mem_rdata;
                bus_be_q   <= '1;
            end
        end
    end

    // Read side: a sampled bus word is pushed into the OUT buffer next cycle.
    always_ff @(posedge fifoClk) begin
        if (!fifoRstn) begin
            mem_wr_en_q <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            mem_wr_en_q <= rd_beat;
            if (rd_beat) begin
                mem_wdata_q <= bus_din;
            end
        end
    end

    assign idle_st   = (state_q == IDLE);
    assign bus_drv   = (state_q == CMD) || (state_q == WR);
    assign oe_n      = !((state_q == TURN) || (state_q == RD));
    assign rd_n      = !((state_q == RD) && !at_max && !mem_full);
    assign mem_rd_en = wr_beat;
    assign xfer_done = (state_q == END);
    assign xfer_len  = (state_q == END) ? cnt_q : '0;

    assign wr_n      = wr_n_q;
    assign bus_dout  = bus_dout_q;
    assign bus_be    = bus_be_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_ep    = mem_ep_q;
    assign grant_err = grant_err_q;

endmodule
